sram_readback_serializer: RTL and testbench
===========================================

// Module: sram_readback_serializer
// PURPOSE
//  Read-back path of the SRAM test chip. Takes a read request (port, address), issues one read on the
//  selected OpenRAM port, captures dout, and shifts a {port, addr, data} frame out serially, MSB first.
//  Feeds the host/pico side. The write/capture path drives the SRAM inputs.
//  The top-level mux gives this block the SRAM pins while readback mode is selected.
// PARAMETERS
//  DATA_W        32  SRAM word width (dout0/dout1 width)
//  ADDR_W         8  SRAM address width
//  SRAM_LATENCY   1  cycles from csb low edge to valid dout (>=1)
// PORTS
//  clk_in     in   1       single clock; all state on rising edge
//  resetn     in   1       asynchronous, active-low reset
//  req_valid  in   1       read request valid
//  req_ready  out  1       block can accept a request (IDLE only)
//  req_port   in   1       0 = port0 (R/W), 1 = port1 (RO)
//  req_addr   in   ADDR_W  word address
//  csb0       out  1       port0 chip select, active low
//  web0       out  1       port0 write enable, active low; constant 1 (read only)
//  addr0      out  ADDR_W  port0 address
//  dout0      in   DATA_W  port0 read data
//  csb1       out  1       port1 chip select, active low
//  addr1      out  ADDR_W  port1 address
//  dout1      in   DATA_W  port1 read data
//  sout_data  out  1       serial frame bit
//  sout_valid out  1       sout_data valid
//  sout_ready in   1       consumer accepts the current bit
//  sout_last  out  1       current bit is the final bit of the frame
// BEHAVIOUR
//  FRAME_W = 1+ADDR_W+DATA_W (41 by default). Frame = {port, addr, data}, sent MSB first.
//  Reset values: csb0=csb1=1, web0=1, addr0=addr1=0, req_ready=1, sout_valid=0, sout_data=0, sout_last=0.
//  FSM states: IDLE -> ISSUE -> WAIT -> SHIFT -> IDLE.
//   IDLE: req_ready=1. If req_valid, latch port/addr and go to ISSUE next cycle.
//   ISSUE: exactly one cycle. Selected csbN=0 and addrN=latched addr. The other csb stays 1.
//    Go to WAIT and load lat_cnt=SRAM_LATENCY-1.
//   WAIT: csbN back to 1; addrN holds its value. Decrement lat_cnt each cycle.
//    On the cycle lat_cnt==0, load shreg={port,addr,doutN}, load bit_cnt=FRAME_W-1 and go to SHIFT.
//    Net effect: dout is sampled SRAM_LATENCY cycles after the ISSUE cycle.
//   SHIFT: sout_valid=1, sout_data=shreg[FRAME_W-1], sout_last=(bit_cnt==0).
//    On sout_valid&&sout_ready, shift shreg left by 1 and decrement bit_cnt.
//    On the handshake with sout_last=1, go to IDLE. sout_valid drops the next cycle.
//  Latency: req accept -> first sout_valid = 1 + SRAM_LATENCY + 1 cycles (3 at default).
//  Backpressure: sout_ready low holds sout_data, sout_valid and sout_last stable.
//   sout_valid never drops mid-frame.
//  Requests are ignored while not in IDLE; req_ready=0 there, so no queueing.
//  Registered outputs: req_ready, csbN, addrN, sout_*; no comb path from inputs to outputs.
//  Back-to-back: a request accepted in the IDLE cycle after the last handshake issues on the next cycle.
//   That gives a 1-cycle gap between frames.
//  Reset mid-operation (any state): return to IDLE immediately and force all outputs to reset values.
//   A partial frame is discarded and is not resumed after reset.
//  Width rules: lat_cnt is $clog2(SRAM_LATENCY+1) bits; bit_cnt is $clog2(FRAME_W) bits.
//   No counter wraps: each counter is loaded before use and stops at 0.
//  Illegal: SRAM_LATENCY=0 must fail elaboration (generate-time $error).
// TESTING
//  1 Reset: assert resetn=0 mid-SHIFT -> next edge all outputs at reset values; req_ready=1 after release.
//  2 Port0 read, sout_ready=1: req_port=0, addr=8'h3C, dout0=32'hDEADBEEF.
//    -> csb0 low exactly 1 cycle with addr0=3C; csb1 stays 1.
//    -> 41 bits = {0,3C,DEADBEEF} MSB first; sout_last only on bit 41; first bit 3 cycles after accept.
//  3 Port1 read: port=1, addr=8'hFF, dout1=32'h00000001.
//    -> frame {1,FF,00000001}; csb0 never low; web0 stays 1.
//  4 Backpressure: random sout_ready with 50% duty on frame {0,A5,12345678}.
//    -> bits unchanged while ready low; reassembled frame matches; no lost or duplicated bits.
//  5 Request during busy: pulse req_valid in WAIT and SHIFT.
//    -> ignored, req_ready=0, no extra csb pulse; the request held until IDLE is served after the frame.
//  6 SRAM_LATENCY=3: dout changes each cycle after ISSUE -> value from ISSUE+3 captured; first bit at +5.

Source files
------------

// File: rtl/sram_readback_serializer.sv
// sram_readback_serializer
//   Read-back path of the SRAM test chip. It accepts one read request
//   (port, address) and issues a single read on the selected OpenRAM port.
//   It captures the returned word and shifts a {port, addr, data} frame out
//   serially, MSB first, towards the host side.
//
// Ports
//   clk_in, resetn          clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_port, req_addr      0 = port0 (R/W), 1 = port1 (RO); word address
//   csb0, web0, addr0       port0 chip select (low), write enable (tied high), address
//   dout0                   port0 read data
//   csb1, addr1, dout1      port1 chip select (low), address, read data
//   sout_data/valid/ready   serial frame bit with valid/ready handshake
//   sout_last               marks the final bit of the frame
module sram_readback_serializer #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 8,
   parameter int SRAM_LATENCY = 1
) (
   input  logic              clk_in,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_port,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              csb0,
   output logic              web0,
   output logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] dout0,
   output logic              csb1,
   output logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] dout1,
   output logic              sout_data,
   output logic              sout_valid,
   input  logic              sout_ready,
   output logic              sout_last
);

   localparam int FRAME_W = 1 + ADDR_W + DATA_W;
   localparam int LAT_W   = (SRAM_LATENCY < 1) ? 1 : $clog2(SRAM_LATENCY + 1);
   localparam int BIT_W   = $clog2(FRAME_W);

   generate
      if (SRAM_LATENCY < 1) begin : g_bad_latency
         $error("sram_readback_serializer: SRAM_LATENCY must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_SHIFT
   } state_t;

   state_t             state, state_nxt;
   logic               port_q, port_nxt;
   logic [ADDR_W-1:0]  addr_q, addr_nxt;
   logic [LAT_W-1:0]   lat_cnt, lat_nxt;
   logic [BIT_W-1:0]   bit_cnt, bit_nxt;
   logic [FRAME_W-1:0] shreg, shreg_nxt;
   logic               csb0_nxt, csb1_nxt;
   logic [ADDR_W-1:0]  addr0_nxt, addr1_nxt;
   logic               req_ready_nxt, sout_valid_nxt, sout_data_nxt, sout_last_nxt;

   // Port0 is only ever read from this block.
   assign web0 = 1'b1;

   // Control state and all registered outputs; reset forces them back to idle.
   always_ff @(posedge clk_in or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         csb0       <= 1'b1;
         csb1       <= 1'b1;
         addr0      <= '0;
         addr1      <= '0;
         req_ready  <= 1'b1;
         sout_valid <= 1'b0;
         sout_data  <= 1'b0;
         sout_last  <= 1'b0;
      end else begin
         state      <= state_nxt;
         csb0       <= csb0_nxt;
         csb1       <= csb1_nxt;
         addr0      <= addr0_nxt;
         addr1      <= addr1_nxt;
         req_ready  <= req_ready_nxt;
         sout_valid <= sout_valid_nxt;
         sout_data  <= sout_data_nxt;
         sout_last  <= sout_last_nxt;
      end
   end

   // Datapath registers: always loaded before they are consumed, so no reset.
   always_ff @(posedge clk_in) begin
      port_q  <= port_nxt;
      addr_q  <= addr_nxt;
      lat_cnt <= lat_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
   end

   always_comb begin
      state_nxt = state;
      port_nxt  = port_q;
      addr_nxt  = addr_q;
      lat_nxt   = lat_cnt;
      bit_nxt   = bit_cnt;
      shreg_nxt = shreg;
      csb0_nxt  = 1'b1;
      csb1_nxt  = 1'b1;
      addr0_nxt = addr0;
      addr1_nxt = addr1;

      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               port_nxt  = req_port;
               addr_nxt  = req_addr;
               state_nxt = ST_ISSUE;
               // Chip select and address go out registered, so the select
               // pulse lines up exactly with the ISSUE cycle.
               if (req_port) begin
                  csb1_nxt  = 1'b0;
                  addr1_nxt = req_addr;
               end else begin
                  csb0_nxt  = 1'b0;
                  addr0_nxt = req_addr;
               end
            end
         end
         ST_ISSUE: begin
            state_nxt = ST_WAIT;
            lat_nxt   = LAT_W'(SRAM_LATENCY - 1);
         end
         ST_WAIT: begin
            if (lat_cnt == '0) begin
               shreg_nxt = {port_q, addr_q, (port_q ? dout1 : dout0)};
               bit_nxt   = BIT_W'(FRAME_W - 1);
               state_nxt = ST_SHIFT;
            end else begin
               lat_nxt = lat_cnt - LAT_W'(1);
            end
         end
         ST_SHIFT: begin
            if (sout_valid && sout_ready) begin
               shreg_nxt = {shreg[FRAME_W-2:0], 1'b0};
               if (bit_cnt == '0) begin
                  state_nxt = ST_IDLE;
               end else begin
                  bit_nxt = bit_cnt - BIT_W'(1);
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Outputs are precomputed from the next state so they can be registered
      // without adding a cycle of latency.
      req_ready_nxt  = (state_nxt == ST_IDLE);
      sout_valid_nxt = (state_nxt == ST_SHIFT);
      sout_data_nxt  = sout_valid_nxt & shreg_nxt[FRAME_W-1];
      sout_last_nxt  = sout_valid_nxt && (bit_nxt == '0);
   end

endmodule

// File: tb/tb_sram_readback_serializer.sv
// Bench for sram_readback_serializer: a default instance (SRAM_LATENCY=1)
// backed by a small registered SRAM model, and a second instance with
// SRAM_LATENCY=3 whose port0 data changes every cycle.
module tb_sram_readback_serializer;

   localparam int FW = 41;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid, req_ready, req_port;
   logic [7:0]  req_addr;
   logic        csb0, web0, csb1;
   logic [7:0]  addr0, addr1;
   logic [31:0] dout0 = '0, dout1 = '0;
   logic        sout_data, sout_valid, sout_ready, sout_last;

   logic        req_valid3, req_ready3, req_port3;
   logic [7:0]  req_addr3;
   logic        csb0_3, web0_3, csb1_3;
   logic [7:0]  addr0_3, addr1_3;
   logic [31:0] cnt3 = 32'h0000_1000;
   logic [31:0] dout1_3 = 32'h0;
   logic        sout_data3, sout_valid3, sout_ready3, sout_last3;

   always #5 clk = ~clk;

   sram_readback_serializer dut (
      .clk_in(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_port(req_port), .req_addr(req_addr),
      .csb0(csb0), .web0(web0), .addr0(addr0), .dout0(dout0),
      .csb1(csb1), .addr1(addr1), .dout1(dout1),
      .sout_data(sout_data), .sout_valid(sout_valid), .sout_ready(sout_ready), .sout_last(sout_last)
   );

   sram_readback_serializer #(.SRAM_LATENCY(3)) dut3 (
      .clk_in(clk), .resetn(resetn),
      .req_valid(req_valid3), .req_ready(req_ready3), .req_port(req_port3), .req_addr(req_addr3),
      .csb0(csb0_3), .web0(web0_3), .addr0(addr0_3), .dout0(cnt3),
      .csb1(csb1_3), .addr1(addr1_3), .dout1(dout1_3),
      .sout_data(sout_data3), .sout_valid(sout_valid3), .sout_ready(sout_ready3), .sout_last(sout_last3)
   );

   // Registered SRAM model: data appears the cycle after the select cycle.
   logic [31:0] mem0 [256];
   logic [31:0] mem1 [256];
   always @(posedge clk) begin
      if (!csb0) dout0 <= mem0[addr0];
      if (!csb1) dout1 <= mem1[addr1];
      cnt3 <= cnt3 + 32'd1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Backpressure driver
   bit bp_en = 1'b0;
   initial begin
      sout_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         sout_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Scoreboard / monitor
   logic [FW-1:0] exp_q [$];
   logic [FW-1:0] asm_frame;
   int            nbits = 0;
   int            frames_done = 0;
   int            csb0_lows = 0, csb1_lows = 0, web_lows = 0;
   bit            hold_pend = 1'b0;
   logic [2:0]    hold_val;

   initial begin
      forever begin
         @(negedge clk);
         if (!resetn) begin
            nbits     = 0;
            asm_frame = '0;
            hold_pend = 1'b0;
         end else begin
            if (hold_pend)
               check("bp_hold", 64'({sout_valid, sout_data, sout_last}), 64'(hold_val));
            if (!csb0) csb0_lows++;
            if (!csb1) csb1_lows++;
            if (!web0) web_lows++;
            if (sout_valid && sout_ready) begin
               asm_frame = {asm_frame[FW-2:0], sout_data};
               nbits++;
               if (sout_last) begin
                  check("frame_len", 64'(nbits), 64'(FW));
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL frame_unexpected: got %h expected none", asm_frame);
                  end else begin
                     check("frame_data", 64'(asm_frame), 64'(exp_q.pop_front()));
                  end
                  nbits = 0;
                  frames_done++;
               end else if (nbits >= FW) begin
                  errors++;
                  $display("FAIL frame_no_last: got %0d bits expected last at %0d", nbits, FW);
                  nbits = 0;
               end
            end
            hold_pend = sout_valid && !sout_ready;
            hold_val  = {sout_valid, sout_data, sout_last};
         end
      end
   end

   task automatic wait_frame(input int budget);
      int fd = frames_done;
      int k = 0;
      while (frames_done == fd && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("frame_timeout", 64'(frames_done != fd), 64'(1));
   endtask

   // Issue one request and check the select pulse and first-bit latency.
   task automatic run_req(input logic port, input logic [7:0] addr);
      int k = 0;
      @(negedge clk);
      while (!req_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("req_ready_idle", 64'(req_ready), 64'(1));
      req_valid = 1'b1;
      req_port  = port;
      req_addr  = addr;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("issue_csb", 64'({csb0, csb1}), 64'(port ? 2'b10 : 2'b01));
      check("issue_addr", 64'(port ? addr1 : addr0), 64'(addr));
      check("issue_busy", 64'(req_ready), 64'(0));
      @(negedge clk);
      check("wait_csb", 64'({csb0, csb1}), 64'(2'b11));
      check("wait_addr_hold", 64'(port ? addr1 : addr0), 64'(addr));
      @(negedge clk);
      check("first_bit_latency", 64'(sout_valid), 64'(1));
   endtask

   typedef struct {
      logic          port;
      logic [7:0]    addr;
      logic [31:0]   data;
      bit            bp;
      logic [FW-1:0] frame;
   } vec_t;

   vec_t vecs [4];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, w, fd, k;
      bit busy_ok;
      logic [31:0]   vi;
      logic [FW-1:0] f3;

      vecs[0] = '{1'b0, 8'h3C, 32'hDEADBEEF, 1'b0, 41'h03CDEADBEEF};
      vecs[1] = '{1'b1, 8'hFF, 32'h00000001, 1'b0, 41'h1FF00000001};
      vecs[2] = '{1'b0, 8'hA5, 32'h12345678, 1'b1, 41'h0A512345678};
      vecs[3] = '{1'b1, 8'h00, 32'h80000000, 1'b1, 41'h10080000000};

      resetn = 1'b0;
      req_valid = 1'b0; req_port = 1'b0; req_addr = '0;
      req_valid3 = 1'b0; req_port3 = 1'b0; req_addr3 = '0; sout_ready3 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 64'({csb0, csb1, web0, addr0, addr1, req_ready, sout_valid, sout_data, sout_last}),
            64'({1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}));
      resetn = 1'b1;
      @(negedge clk);
      #1 check("req_ready_after_reset", 64'(req_ready), 64'(1));

      // Table-driven single reads
      for (int i = 0; i < 4; i++) begin
         mem0[vecs[i].addr] = vecs[i].port ? ~vecs[i].data : vecs[i].data;
         mem1[vecs[i].addr] = vecs[i].port ? vecs[i].data : ~vecs[i].data;
         c0 = csb0_lows; c1 = csb1_lows; w = web_lows;
         exp_q.push_back(vecs[i].frame);
         bp_en = vecs[i].bp;
         run_req(vecs[i].port, vecs[i].addr);
         wait_frame(600);
         bp_en = 1'b0;
         check("csb0_pulses", 64'(csb0_lows - c0), 64'(vecs[i].port ? 0 : 1));
         check("csb1_pulses", 64'(csb1_lows - c1), 64'(vecs[i].port ? 1 : 0));
         check("web0_high", 64'(web_lows - w), 64'(0));
      end

      // Request while busy: held from WAIT through SHIFT, served right after the frame
      mem0[8'h42] = 32'hCAFEF00D; mem1[8'h42] = ~32'hCAFEF00D;
      mem1[8'h77] = 32'h0BADC0DE; mem0[8'h77] = ~32'h0BADC0DE;
      c0 = csb0_lows; c1 = csb1_lows; fd = frames_done;
      exp_q.push_back(41'h042CAFEF00D);
      @(negedge clk);
      req_valid = 1'b1; req_port = 1'b0; req_addr = 8'h42;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      req_valid = 1'b1; req_port = 1'b1; req_addr = 8'h77;
      exp_q.push_back(41'h1770BADC0DE);
      busy_ok = 1'b1;
      k = 0;
      while (frames_done == fd && k < 200) begin
         @(negedge clk);
         #1;
         if (req_ready) busy_ok = 1'b0;
         k++;
      end
      check("busy_ready_low", 64'(busy_ok), 64'(1));
      check("busy_no_extra_csb", 64'({32'(csb0_lows - c0), 32'(csb1_lows - c1)}), {32'd1, 32'd0});
      @(negedge clk);
      #1 check("idle_gap_ready", 64'({req_ready, sout_valid}), 64'(2'b10));
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("back_to_back_issue", 64'({csb1, addr1}), 64'({1'b0, 8'h77}));
      wait_frame(200);

      // Reset in the middle of a frame
      exp_q.push_back(41'h03CDEADBEEF);
      run_req(1'b0, 8'h3C);
      repeat (5) @(negedge clk);
      fd = frames_done;
      resetn = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1 check("midframe_reset", 64'({csb0, csb1, web0, addr0, addr1, req_ready, sout_valid, sout_data, sout_last}),
               64'({1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}));
      @(negedge clk);
      resetn = 1'b1;
      repeat (60) @(negedge clk);
      #1 check("no_resume_after_reset", 64'({req_ready, sout_valid, 32'(frames_done - fd)}), {30'd0, 1'b1, 1'b0, 32'd0});

      // SRAM_LATENCY=3 instance: data changes every cycle
      @(negedge clk);
      req_valid3 = 1'b1; req_port3 = 1'b0; req_addr3 = 8'h11;
      @(posedge clk);
      #1 req_valid3 = 1'b0;
      @(negedge clk);
      check("lat3_issue_csb", 64'({csb0_3, csb1_3, addr0_3}), 64'({1'b0, 1'b1, 8'h11}));
      vi = cnt3;
      k = 1;
      while (!sout_valid3 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("lat3_first_bit", 64'(k), 64'(5));
      f3 = '0;
      k = 0;
      while (k < 60) begin
         if (sout_valid3 && sout_ready3) begin
            f3 = {f3[FW-2:0], sout_data3};
            if (sout_last3) break;
         end
         @(negedge clk);
         k++;
      end
      check("lat3_frame", 64'(f3), 64'({1'b0, 8'h11, vi + 32'd3}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
